// File: rtl/riscv_pkg.sv
// Shared pipeline encodings: forwarding selects, result-source codes and hazard FSM states.
package riscv_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    RUN    = 1'b0,
    MCBUSY = 1'b1
  } hazState_t;

endpackage

// File: rtl/hazard_perf_ctr.sv
// Saturating event counter: advances on inc, holds at all-ones.
module hazard_perf_ctr #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {PERF_W{1'b1}})) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX forwarding, load-use stall, branch flush and multi-cycle op hold.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        Rs1E,
  input  logic [4:0]        Rs2E,
  input  logic [4:0]        RdE,
  input  logic [4:0]        RdM,
  input  logic [4:0]        RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  input  logic              McDoneE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt,
  output logic [PERF_W-1:0] McCnt,
`endif
  output logic              McErr
);

  localparam int unsigned CNT_W = $clog2(MC_TIMEOUT + 1);

  hazState_t        state;
  logic [CNT_W-1:0] mcCnt;
  logic             busy;
  logic             lwStall;
  logic             mcEnter;

  function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic [4:0] rdM,
                                        input logic wM, input logic [4:0] rdW, input logic wW);
    if (wM && (rdM != 5'd0) && (rdM == rs))      return FWD_MEM;
    else if (wW && (rdW != 5'd0) && (rdW == rs)) return FWD_WB;
    else                                         return FWD_NONE;
  endfunction

  assign ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign lwStall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign busy    = (((state == RUN) && McStartE) || (state == MCBUSY)) && !McDoneE;
  assign mcEnter = (state == RUN) && McStartE && !McDoneE;

  // Multi-cycle op tracker; the counter holds busy cycles already spent, including the start cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      mcCnt <= '0;
      McErr <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mcEnter) begin
            state <= MCBUSY;
            mcCnt <= CNT_W'(1);
          end
        end
        MCBUSY: begin
          if (McDoneE) begin
            state <= RUN;
            mcCnt <= '0;
          end else if (mcCnt >= CNT_W'(MC_TIMEOUT - 1)) begin
            state <= RUN;
            mcCnt <= '0;
            McErr <= 1'b1;
          end else begin
            mcCnt <= mcCnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          mcCnt <= '0;
        end
      endcase
    end
  end

  // Stall/flush must react in the same cycle as the EX-stage events, so they are decoded directly.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (!reset) begin
      if (busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        StallF = lwStall;
        StallD = lwStall;
        FlushD = PCSrcE;
        FlushE = lwStall || PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_ctr #(.PERF_W(PERF_W)) uStallCtr (
    .clk(clk), .reset(reset), .inc(StallD), .count(StallCnt)
  );
  hazard_perf_ctr #(.PERF_W(PERF_W)) uFlushCtr (
    .clk(clk), .reset(reset), .inc(PCSrcE && !busy), .count(FlushCnt)
  );
  hazard_perf_ctr #(.PERF_W(PERF_W)) uMcCtr (
    .clk(clk), .reset(reset), .inc(mcEnter), .count(McCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; perf counter checks are built when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam int unsigned PW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, McStartE, McDoneE;
  logic [1:0] ResultSrcE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McErr;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [PW-1:0] StallCnt, FlushCnt, McCnt;
`endif

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_TIMEOUT(8), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .McCnt(McCnt),
`endif
    .McErr(McErr)
  );

  // Packs {StallF,StallD,StallE,FlushD,FlushE,FlushM} for compact comparisons.
  function automatic logic [5:0] ctl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  endfunction

  task automatic clearInputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    PCSrcE = 0; McStartE = 0; McDoneE = 0;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b1;
    RdM = 5'd9; RegWriteM = 1'b1; Rs1E = 5'd9;
    ResultSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4; PCSrcE = 1'b1; McStartE = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL reset_ctl got=%b exp=000000", ctl()); end
    nChecks++;
    if (McErr !== 1'b0) begin nFails++; $display("FAIL reset_mcerr got=%b exp=0", McErr); end
    nChecks++;
    if (ForwardAE !== 2'b10) begin nFails++; $display("FAIL reset_fwd got=%b exp=10", ForwardAE); end
    clearInputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL post_reset_ctl got=%b exp=000000", ctl()); end
  endtask

  task automatic test_forward();
    logic [4:0]  v [6][6];
    logic [3:0]  e [6];
    // {RdM, RegWriteM, RdW, RegWriteW, Rs1E, Rs2E} -> {ForwardAE, ForwardBE}
    v[0] = '{5'd5, 5'd1, 5'd5, 5'd1, 5'd5, 5'd0};  e[0] = 4'b10_00;
    v[1] = '{5'd0, 5'd1, 5'd5, 5'd1, 5'd5, 5'd0};  e[1] = 4'b01_00;
    v[2] = '{5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0};  e[2] = 4'b00_00;
    v[3] = '{5'd3, 5'd0, 5'd3, 5'd1, 5'd1, 5'd3};  e[3] = 4'b00_01;
    v[4] = '{5'd3, 5'd1, 5'd3, 5'd1, 5'd3, 5'd3};  e[4] = 4'b10_10;
    v[5] = '{5'd6, 5'd0, 5'd6, 5'd0, 5'd6, 5'd6};  e[5] = 4'b00_00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      RdM = v[i][0]; RegWriteM = v[i][1][0]; RdW = v[i][2]; RegWriteW = v[i][3][0];
      Rs1E = v[i][4]; Rs2E = v[i][5];
      #1;
      nChecks++;
      if ({ForwardAE, ForwardBE} !== e[i]) begin
        nFails++;
        $display("FAIL forward_%0d got=%b exp=%b", i, {ForwardAE, ForwardBE}, e[i]);
      end
    end
    clearInputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd2;
    #1;
    nChecks++;
    if (ctl() !== 6'b110010) begin nFails++; $display("FAIL lw_stall got=%b exp=110010", ctl()); end
    @(negedge clk);
    clearInputs();
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL lw_release got=%b exp=000000", ctl()); end
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL lw_x0 got=%b exp=000000", ctl()); end
    @(negedge clk);
    ResultSrcE = 2'b10; RdE = 5'd7; Rs1D = 5'd7;
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL lw_notload got=%b exp=000000", ctl()); end
    clearInputs();
  endtask

  task automatic test_branch();
    @(negedge clk);
    PCSrcE = 1'b1;
    #1;
    nChecks++;
    if (ctl() !== 6'b000110) begin nFails++; $display("FAIL branch got=%b exp=000110", ctl()); end
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd12; Rs1D = 5'd12;
    #1;
    nChecks++;
    if (ctl() !== 6'b110110) begin nFails++; $display("FAIL branch_lw got=%b exp=110110", ctl()); end
    clearInputs();
  endtask

  task automatic test_multicycle();
    @(negedge clk);
    McStartE = 1'b1;
    #1;
    nChecks++;
    if (ctl() !== 6'b111001) begin nFails++; $display("FAIL mc_start got=%b exp=111001", ctl()); end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      McStartE = 1'b0;
      PCSrcE = (i == 2);
      #1;
      nChecks++;
      if (ctl() !== 6'b111001) begin nFails++; $display("FAIL mc_busy_%0d got=%b exp=111001", i, ctl()); end
    end
    @(negedge clk);
    PCSrcE = 1'b0; McDoneE = 1'b1;
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL mc_done got=%b exp=000000", ctl()); end
    @(negedge clk);
    McDoneE = 1'b0; PCSrcE = 1'b1;
    #1;
    nChecks++;
    if (ctl() !== 6'b000110) begin nFails++; $display("FAIL mc_after got=%b exp=000110", ctl()); end
    @(negedge clk);
    PCSrcE = 1'b0; McStartE = 1'b1; McDoneE = 1'b1;
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL mc_single got=%b exp=000000", ctl()); end
    @(negedge clk);
    clearInputs();
    #1;
    nChecks++;
    if (ctl() !== 6'b000000) begin nFails++; $display("FAIL mc_single_run got=%b exp=000000", ctl()); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    McStartE = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk);
        McStartE = 1'b0;
        #1;
      end
      nChecks++;
      if ({StallF, McErr} !== 2'b10) begin
        nFails++;
        $display("FAIL to_busy_%0d got={StallF,McErr}=%b exp=10", i, {StallF, McErr});
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      nChecks++;
      if ({StallF, McErr} !== 2'b01) begin
        nFails++;
        $display("FAIL to_after_%0d got={StallF,McErr}=%b exp=01", i, {StallF, McErr});
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    McStartE = 1'b1;
    @(negedge clk);
    McStartE = 1'b0;
    #1;
    nChecks++;
    if (ctl() !== 6'b111001) begin nFails++; $display("FAIL rmb_busy got=%b exp=111001", ctl()); end
    #1;
    reset = 1'b1;
    #1;
    nChecks++;
    if ({ctl(), McErr} !== 7'b0000000) begin
      nFails++;
      $display("FAIL rmb_drop got=%b exp=0000000", {ctl(), McErr});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    nChecks++;
    if ({ctl(), McErr} !== 7'b0000000) begin
      nFails++;
      $display("FAIL rmb_run got=%b exp=0000000", {ctl(), McErr});
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    reset = 1'b1;
    #1;
    nChecks++;
    if ({StallCnt, FlushCnt, McCnt} !== 12'd0) begin
      nFails++;
      $display("FAIL perf_reset got=%h exp=000", {StallCnt, FlushCnt, McCnt});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        #1;
        nChecks++;
        if (StallCnt !== 4'd3) begin nFails++; $display("FAIL perf_stall3 got=%0d exp=3", StallCnt); end
      end
      ResultSrcE = 2'b01; RdE = 5'd8; Rs1D = 5'd8;
    end
    @(negedge clk);
    clearInputs();
    PCSrcE = 1'b1;
    @(negedge clk);
    PCSrcE = 1'b0; McStartE = 1'b1;
    @(negedge clk);
    McStartE = 1'b0; McDoneE = 1'b1;
    @(negedge clk);
    McDoneE = 1'b0;
    #1;
    nChecks++;
    if (StallCnt !== 4'd15) begin nFails++; $display("FAIL perf_sat got=%0d exp=15", StallCnt); end
    nChecks++;
    if ({FlushCnt, McCnt} !== 8'h11) begin
      nFails++;
      $display("FAIL perf_flush_mc got=%h exp=11", {FlushCnt, McCnt});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_multicycle();
    test_timeout();
    test_reset_mid_busy();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
